// File: rtl/tuning_word_ctrl.sv
// Frequency-select to DDS tuning-word controller with serial double-dabble BCD readout.
// Optional UP/DOWN stepping of the held value is compiled in with macro TW_STEP_EN.
module tuning_word_ctrl #(
  parameter int unsigned SW_W   = 10,
  parameter int unsigned ACC_W  = 28,
  parameter int unsigned K_UNIT = 26844,
  parameter int unsigned DIGITS = 4
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic                LOAD,
  input  logic                CLEAR,
`ifdef TW_STEP_EN
  input  logic                UP,
  input  logic                DOWN,
`endif
  input  logic [SW_W-1:0]     SW,
  output logic [ACC_W-1:0]    M,
  output logic [4*DIGITS-1:0] BCD,
  output logic                OVF,
  output logic                BUSY,
  output logic                VALID
);

  // Enough BCD digits to hold any SW_W-bit value (one digit covers more than 3 bits).
  localparam int unsigned NDig  = (SW_W + 2) / 3;
  localparam int unsigned BcdW  = 4 * NDig;
  localparam int unsigned OutW  = 4 * DIGITS;
  localparam int unsigned FullW = (BcdW > OutW) ? BcdW : OutW;
  localparam int unsigned CntW  = $clog2(SW_W + 1);

  localparam logic [ACC_W-1:0] KUnit   = ACC_W'(K_UNIT);
  localparam logic [SW_W-1:0]  ValMax  = '1;
  localparam logic [CntW-1:0]  CntLast = CntW'(SW_W - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q;
  logic [SW_W-1:0]   value_q;
  logic [CntW-1:0]   cnt_q;
  logic [BcdW-1:0]   bcd_acc_q;
  logic [ACC_W-1:0]  mul_acc_q;
  logic [ACC_W-1:0]  m_q;
  logic [OutW-1:0]   bcd_q;
  logic              ovf_q;
  logic              busy_q;
  logic              valid_q;

  logic              bit_in;
  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_step;
  logic [ACC_W-1:0]  mul_step;
  logic [FullW-1:0]  bcd_full;
  logic [OutW-1:0]   bcd_fin;
  logic              ovf_fin;
  logic              start;
  logic [SW_W-1:0]   value_nxt;

  // Value bits are consumed MSB first; the multiplier shares the same bit stream.
  always_comb begin
    bit_in = 1'b0;
    for (int unsigned i = 0; i < SW_W; i++) begin
      if (cnt_q == CntW'(SW_W - 1 - i)) bit_in = value_q[i];
    end

    bcd_adj = bcd_acc_q;
    for (int unsigned i = 0; i < NDig; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_step = BcdW'({bcd_adj, bit_in});
    mul_step = ACC_W'({mul_acc_q, 1'b0}) + (bit_in ? KUnit : '0);
  end

  // Digits beyond the display width flag overflow and force the display to all nines.
  always_comb begin
    bcd_full = FullW'(bcd_step);
    ovf_fin  = 1'b0;
    for (int unsigned j = DIGITS; j < NDig; j++) begin
      ovf_fin = ovf_fin | (|bcd_full[4*j +: 4]);
    end
    bcd_fin = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_fin[4*i +: 4] = ovf_fin ? 4'd9 : bcd_full[4*i +: 4];
    end
  end

  always_comb begin
    start     = 1'b0;
    value_nxt = value_q;
    if (state_q == StIdle) begin
      if (LOAD) begin
        start     = 1'b1;
        value_nxt = SW;
      end
`ifdef TW_STEP_EN
      else if (UP) begin
        start = 1'b1;
        if (value_q != ValMax) value_nxt = value_q + 1'b1;
      end else if (DOWN) begin
        start = 1'b1;
        if (value_q != '0) value_nxt = value_q - 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST || CLEAR) begin
      state_q   <= StIdle;
      value_q   <= '0;
      cnt_q     <= '0;
      bcd_acc_q <= '0;
      mul_acc_q <= '0;
      m_q       <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (start) begin
            value_q   <= value_nxt;
            cnt_q     <= '0;
            bcd_acc_q <= '0;
            mul_acc_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StConv;
          end
        end
        StConv: begin
          bcd_acc_q <= bcd_step;
          mul_acc_q <= mul_step;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            m_q     <= mul_step;
            bcd_q   <= bcd_fin;
            ovf_q   <= ovf_fin;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign M     = m_q;
  assign BCD   = bcd_q;
  assign OVF   = ovf_q;
  assign BUSY  = busy_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_tuning_word_ctrl.sv
// Bench for tuning_word_ctrl: vector table, random values against a decimal model,
// and hand sequences for abort, ignored loads and reset.
module tb_tuning_word_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic        clear;
  logic [9:0]  sw;
  logic [27:0] m, m3;
  logic [15:0] bcd;
  logic [11:0] bcd3;
  logic        ovf, ovf3, busy, busy3, valid, valid3;
`ifdef TW_STEP_EN
  logic        up;
  logic        down;
`endif

  int nvec = 0;
  int nerr = 0;

  tuning_word_ctrl dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .LOAD     (load),
    .CLEAR    (clear),
`ifdef TW_STEP_EN
    .UP       (up),
    .DOWN     (down),
`endif
    .SW       (sw),
    .M        (m),
    .BCD      (bcd),
    .OVF      (ovf),
    .BUSY     (busy),
    .VALID    (valid)
  );

  tuning_word_ctrl #(.DIGITS(3)) dut3 (
    .CLOCK_50 (clk),
    .RST      (rst),
    .LOAD     (load),
    .CLEAR    (clear),
`ifdef TW_STEP_EN
    .UP       (up),
    .DOWN     (down),
`endif
    .SW       (sw),
    .M        (m3),
    .BCD      (bcd3),
    .OVF      (ovf3),
    .BUSY     (busy3),
    .VALID    (valid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sw;
    logic [27:0] m;
    logic [15:0] bcd;
    logic        ovf;
    logic [11:0] bcd3;
    logic        ovf3;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: product modulo 2^28 and digit-by-digit decimal, saturating to nines.
  function automatic void model(input int v, input int digits, output logic [27:0] em,
                                output logic [15:0] eb, output logic eo);
    longint prod;
    int     lim;
    int     tmp;
    prod = longint'(v) * 64'd26844;
    em   = prod[27:0];
    lim  = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    lim = lim - 1;
    eo  = (v > lim);
    eb  = '0;
    tmp = v;
    for (int d = 0; d < digits; d++) begin
      eb[4*d +: 4] = eo ? 4'd9 : 4'(tmp % 10);
      tmp = tmp / 10;
    end
  endfunction

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      if (valid === 1'b1 || valid3 === 1'b1) cnt++;
      tick();
    end
  endtask

  // kind: 0 LOAD, 1 UP, 2 DOWN. Called in cycle 0, returns in cycle 12.
  task automatic expect_conv(input int kind, input int sw_in, input logic [27:0] em,
                             input logic [15:0] eb, input logic eo,
                             input logic [11:0] eb3, input logic eo3);
    logic [27:0] m_before;
    m_before = m;
    if (kind == 0) begin
      load = 1'b1;
      sw   = 10'(sw_in);
    end
`ifdef TW_STEP_EN
    if (kind == 1) up = 1'b1;
    if (kind == 2) down = 1'b1;
`endif
    tick();
    load = 1'b0;
`ifdef TW_STEP_EN
    up   = 1'b0;
    down = 1'b0;
`endif
    for (int c = 1; c <= 10; c++) begin
      chk("conv_busy_valid_m", {busy, valid, m}, {1'b1, 1'b0, m_before});
      tick();
    end
    chk("done_valid_busy", {valid, busy, valid3}, {1'b1, 1'b0, 1'b1});
    chk("done_m", m, em);
    chk("done_bcd", bcd, eb);
    chk("done_ovf", ovf, eo);
    chk("done3_m", m3, em);
    chk("done3_bcd", bcd3, eb3);
    chk("done3_ovf", ovf3, eo3);
    tick();
    chk("after_valid", {valid, busy}, 2'b00);
  endtask

  initial begin
    logic [27:0] em, em3;
    logic [15:0] eb, eb3;
    logic        eo, eo3;
    int          v;
    int          nv;
    logic [27:0] cap_m;
    logic [15:0] cap_b;

    tbl[0] = '{sw: 1,    m: 28'd26844,    bcd: 16'h0001, ovf: 1'b0, bcd3: 12'h001, ovf3: 1'b0};
    tbl[1] = '{sw: 1023, m: 28'd27461412, bcd: 16'h1023, ovf: 1'b0, bcd3: 12'h999, ovf3: 1'b1};
    tbl[2] = '{sw: 0,    m: 28'd0,        bcd: 16'h0000, ovf: 1'b0, bcd3: 12'h000, ovf3: 1'b0};
    tbl[3] = '{sw: 999,  m: 28'd26817156, bcd: 16'h0999, ovf: 1'b0, bcd3: 12'h999, ovf3: 1'b0};
    tbl[4] = '{sw: 1000, m: 28'd26844000, bcd: 16'h1000, ovf: 1'b0, bcd3: 12'h999, ovf3: 1'b1};
    tbl[5] = '{sw: 512,  m: 28'd13744128, bcd: 16'h0512, ovf: 1'b0, bcd3: 12'h512, ovf3: 1'b0};

    rst   = 1'b1;
    load  = 1'b0;
    clear = 1'b0;
    sw    = '0;
`ifdef TW_STEP_EN
    up    = 1'b0;
    down  = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", {m, bcd, ovf, busy, valid}, '0);
    chk("reset_outputs3", {m3, bcd3, ovf3, busy3, valid3}, '0);

    foreach (tbl[i]) begin
      expect_conv(0, tbl[i].sw, tbl[i].m, tbl[i].bcd, tbl[i].ovf, tbl[i].bcd3, tbl[i].ovf3);
    end

    for (int r = 0; r < 30; r++) begin
      v = int'($urandom_range(0, 1023));
      model(v, 4, em, eb, eo);
      model(v, 3, em3, eb3, eo3);
      expect_conv(0, v, em, eb, eo, eb3[11:0], eo3);
      repeat ($urandom_range(0, 3)) tick();
    end

    // CLEAR in cycle 5 aborts a conversion.
    load = 1'b1;
    sw   = 10'd500;
    tick();
    load = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_abort_state", {m, bcd, ovf, busy, valid}, '0);
    count_valid(20, nv);
    chk("clear_abort_no_valid", nv, 0);

    // Second LOAD during CONV is dropped.
    load = 1'b1;
    sw   = 10'd7;
    tick();
    load = 1'b0;
    tick();
    tick();
    load = 1'b1;
    sw   = 10'd9;
    tick();
    load  = 1'b0;
    nv    = 0;
    cap_m = '0;
    cap_b = '0;
    for (int c = 0; c < 30; c++) begin
      if (valid === 1'b1) begin
        nv++;
        cap_m = m;
        cap_b = bcd;
      end
      tick();
    end
    chk("dbl_load_valid_count", nv, 1);
    chk("dbl_load_m", cap_m, 28'd187908);
    chk("dbl_load_bcd", cap_b, 16'h0007);

    // CLEAR beats LOAD in the same cycle.
    load  = 1'b1;
    clear = 1'b1;
    sw    = 10'd300;
    tick();
    load  = 1'b0;
    clear = 1'b0;
    chk("clear_load_state", {m, busy, valid}, '0);
    count_valid(20, nv);
    chk("clear_load_no_valid", nv, 0);

    // LOAD while VALID (DONE) is ignored.
    load = 1'b1;
    sw   = 10'd5;
    tick();
    load = 1'b0;
    repeat (10) tick();
    chk("done_load_valid", valid, 1'b1);
    load = 1'b1;
    sw   = 10'd6;
    tick();
    load = 1'b0;
    chk("done_load_busy", busy, 1'b0);
    count_valid(20, nv);
    chk("done_load_no_valid", nv, 0);
    chk("done_load_m", m, 28'd134220);

    // RST mid-conversion.
    load = 1'b1;
    sw   = 10'd123;
    tick();
    load = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort_state", {m, bcd, ovf, busy, valid}, '0);
    count_valid(20, nv);
    chk("rst_abort_no_valid", nv, 0);

`ifdef TW_STEP_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_conv(2, 0, 28'd0, 16'h0000, 1'b0, 12'h000, 1'b0);
    expect_conv(1, 0, 28'd26844, 16'h0001, 1'b0, 12'h001, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tuning_word_ctrl.md
TUNING_WORD_CTRL -- requirements
Module: tuning_word_ctrl

Interface
REQ-001 The block SHALL have parameter SW_W, default 10: width of the frequency-select input, in kHz units.
REQ-002 The block SHALL have parameter ACC_W, default 28: tuning-word (phase accumulator) width.
REQ-003 The block SHALL have parameter K_UNIT, default 26844: tuning-word increment per 1 kHz.
REQ-004 The block SHALL have parameter DIGITS, default 4: number of BCD display digits.
REQ-005 CLOCK_50  input  1  system clock; every register in the block SHALL be clocked on its rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 LOAD  input  1  single-cycle request to capture SW (debounced key pulse, active-high).
REQ-008 CLEAR  input  1  single-cycle request to zero the tuning word and the display.
REQ-009 SW  input  SW_W  requested frequency in kHz.
REQ-010 M  output  ACC_W  tuning word.
REQ-011 BCD  output  4*DIGITS  display digits; digit 0 (units) SHALL occupy bits [3:0].
REQ-012 OVF  output  1  high when the captured value exceeds 10^DIGITS-1.
REQ-013 BUSY  output  1  high while a conversion is in progress.
REQ-014 VALID  output  1  one-cycle pulse when M, BCD and OVF take new values.

Function
REQ-015 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-016 In IDLE, when LOAD=1, the block SHALL capture SW into an internal value register, enter CONV and set BUSY=1 on the same edge.
REQ-017 CONV SHALL run iterative double-dabble binary-to-BCD conversion, one SW_W bit per cycle, for exactly SW_W cycles, and then go to DONE.
REQ-018 In DONE, the block SHALL load M, BCD and OVF in one edge, pulse VALID=1 for one cycle, clear BUSY and return to IDLE.
REQ-019 Latency SHALL be fixed: VALID is high in cycle N+SW_W+1 when LOAD is sampled in cycle N.
REQ-020 M SHALL equal value*K_UNIT, truncated modulo 2^ACC_W.
REQ-021 The multiplier SHALL be registered or multicycle within CONV, and SHALL NOT add latency.
REQ-022 When value > 10^DIGITS-1, BCD SHALL show all digits 9, OVF SHALL be 1, and M SHALL still follow REQ-020.
REQ-023 LOAD in CONV or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-024 CLEAR SHALL act in any state: on the next edge, M=0, BCD=0, OVF=0, VALID=0, BUSY=0, the value register = 0 and the state = IDLE.
REQ-025 A conversion aborted by CLEAR SHALL produce no VALID.
REQ-026 When CLEAR and LOAD are asserted in the same cycle, CLEAR SHALL win and LOAD SHALL be dropped.
REQ-027 M, BCD and OVF SHALL change only in DONE or on CLEAR/RST; they SHALL never show partial results.

Reset
REQ-028 When RST=1 at a rising edge, outputs SHALL be M=0, BCD=0, OVF=0, BUSY=0, VALID=0, the value register = 0 and the state = IDLE.
REQ-029 RST SHALL take priority over CLEAR, LOAD and STEP inputs.
REQ-030 RST asserted in mid-conversion SHALL abort the conversion with no VALID.

Configuration
REQ-031 When macro TW_STEP_EN is defined, the block SHALL have extra inputs UP and DOWN (1 bit each, single-cycle pulses).
REQ-032 With TW_STEP_EN, in IDLE, UP SHALL increment the value register by 1, saturating at 2^SW_W-1.
REQ-033 With TW_STEP_EN, in IDLE, DOWN SHALL decrement the value register by 1, saturating at 0.
REQ-034 With TW_STEP_EN, each step SHALL start a conversion exactly as LOAD does, without sampling SW.
REQ-035 With TW_STEP_EN, input priority SHALL be CLEAR > LOAD > UP > DOWN; UP and DOWN SHALL be ignored while BUSY=1.
REQ-036 When TW_STEP_EN is not defined, the UP and DOWN ports and the step logic SHALL be absent, and behaviour SHALL be REQ-001 to REQ-030 only.

Verification
REQ-037 Defaults, SW=1, LOAD pulsed in cycle 0 -> VALID in cycle 11, M=26844, BCD=16'h0001, OVF=0; BUSY high in cycles 1-10.
REQ-038 SW=1023, LOAD -> M=27461412, BCD=16'h1023, OVF=0.
REQ-039 DIGITS=3, SW=1023, LOAD -> BCD=12'h999, OVF=1, M=27461412.
REQ-040 LOAD with SW=500, then CLEAR in cycle 5 -> no VALID pulse, M=0, BCD=0, BUSY=0 in cycle 6.
REQ-041 LOAD with SW=7, then a second LOAD in cycle 3 with SW=9 -> exactly one VALID, M=187908, BCD=16'h0007.
REQ-042 With TW_STEP_EN, after CLEAR, DOWN -> value stays 0 and VALID shows M=0; then UP -> M=26844, BCD=16'h0001.
